// File: rtl/bcd_val_pkg.sv
// bcd_val_pkg: shared definitions for the BCD-to-binary converter.
//   DIGIT_W      width of one BCD digit
//   state_t      converter FSM states
//   BCD_DIGIT    slice digit n out of a packed BCD vector
`ifndef BCD_VAL_PKG_DEFS
`define BCD_VAL_PKG_DEFS
`define BCD_DIGIT(v, n) v[(n)*4 +: 4]
`endif

package bcd_val_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ADJ
    } state_t;

endpackage

// File: rtl/bcd_val_if.sv
// bcd_val_if: start/ready request bus of the BCD-to-binary converter.
//   start   request conversion of bcd_in (taken only while rdy=1)
//   bcd_in  packed BCD, digit 0 (ones) in [3:0]
//   rdy     converter idle
//   valid   one-cycle pulse, val/err updated
//   val     binary result, held until the next result
//   err     last accepted input contained a digit > 9
// Modports: master = requester, slave = converter.
interface bcd_val_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  rdy;
    logic                  valid;
    logic [BIN_W-1:0]      val;
    logic                  err;

    modport master (
        output start, bcd_in,
        input  rdy, valid, val, err
    );

    modport slave (
        input  start, bcd_in,
        output rdy, valid, val, err
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: combinational per-digit correction for reverse double dabble.
//   i_digit  BCD digit after the right shift
//   o_digit  i_digit - 3 when i_digit >= 8, else i_digit
//   o_gt9    i_digit is not a legal BCD digit
module bcd_digit_adj
    import bcd_val_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit,
    output logic               o_gt9
);

    assign o_digit = (i_digit >= 4'd8) ? (i_digit - 4'd3) : i_digit;
    assign o_gt9   = (i_digit > 4'd9);

endmodule

// File: rtl/bcd_val.sv
// bcd_val: sequential BCD-to-binary converter (reverse double dabble).
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    bcd_val_if slave: start/bcd_in in, rdy/valid/val/err out
// One conversion in flight; result 2*4*DIGITS edges after the capture edge.
// Inputs with a digit > 9 are rejected on the capture edge with err=1.
module bcd_val
    import bcd_val_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic       clk,
    input  logic       reset,
    bcd_val_if.slave   bus
);

    localparam int W     = DIGITS * DIGIT_W;
    localparam int IDX_W = $clog2(W + 1);

    state_t             r_state;
    logic [W-1:0]       r_bcd;
    logic [W-1:0]       r_bin;
    logic [IDX_W-1:0]   r_idx;
    logic               r_rdy;
    logic               r_valid;
    logic               r_err;
    logic [BIN_W-1:0]   r_val;

    logic [W-1:0]       w_adj_in;
    logic [W-1:0]       w_adj_out;
    logic [DIGITS-1:0]  w_gt9;
    logic               w_bad;

    // The digit blocks look at the incoming word while idle (for the > 9
    // check) and at the shift register otherwise (for the -3 correction).
    assign w_adj_in = (r_state == ST_IDLE) ? bus.bcd_in : r_bcd;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .i_digit (`BCD_DIGIT(w_adj_in, g)),
            .o_digit (`BCD_DIGIT(w_adj_out, g)),
            .o_gt9   (w_gt9[g])
        );
    end

    assign w_bad = |w_gt9;

    // Upper result bits are always zero for legal input and are dropped.
    if (W > BIN_W) begin : g_trunc
        logic w_unused_hi;
        assign w_unused_hi = ^r_bin[W-1:BIN_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_idx   <= '0;
            r_rdy   <= 1'b1;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_val   <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (w_bad) begin
                            r_val   <= '0;
                            r_err   <= 1'b1;
                            r_valid <= 1'b1;
                        end else begin
                            r_bcd   <= bus.bcd_in;
                            r_bin   <= '0;
                            r_idx   <= '0;
                            r_rdy   <= 1'b0;
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    {r_bcd, r_bin} <= {r_bcd, r_bin} >> 1;
                    r_idx          <= r_idx + 1'b1;
                    r_state        <= ST_ADJ;
                end
                ST_ADJ: begin
                    r_bcd <= w_adj_out;
                    if (r_idx == IDX_W'(W)) begin
                        r_val   <= BIN_W'(r_bin);
                        r_err   <= 1'b0;
                        r_valid <= 1'b1;
                        r_rdy   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rdy   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rdy   = r_rdy;
    assign bus.valid = r_valid;
    assign bus.val   = r_val;
    assign bus.err   = r_err;

endmodule

// File: tb/tb_bcd_val.sv
// tb_bcd_val: self-checking bench for bcd_val with a decimal reference model.
module tb_bcd_val;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    bcd_val_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_val #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Decimal value of a BCD word; any digit above 9 makes it an error (value 0).
    function automatic void ref_model(input logic [15:0] b, output int unsigned v, output bit e);
        int unsigned d;
        v = 0;
        e = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            d = int'(b[i*4 +: 4]);
            if (d > 9) e = 1'b1;
            v = v * 10 + d;
        end
        if (e) v = 0;
    endfunction

    function automatic logic [15:0] to_bcd(input int unsigned n);
        logic [15:0] r;
        int unsigned x;
        x = n;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic wait_rdy(input string tag);
        int n;
        n = 0;
        while (bus.rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy_wait"}, 32'(bus.rdy), 32'd1);
    endtask

    // Full transaction: capture, latency, result, one-cycle valid, rdy return.
    task automatic convert(input logic [15:0] b, input string tag);
        int unsigned ev;
        bit ee;
        int lat;
        ref_model(b, ev, ee);
        wait_rdy(tag);
        bus.start  = 1'b1;
        bus.bcd_in = b;
        @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bcd_in = 16'($urandom);
        if (ee) begin
            chk({tag, "_bad_rdy"},   32'(bus.rdy),   32'd1);
            chk({tag, "_bad_valid"}, 32'(bus.valid), 32'd1);
            chk({tag, "_bad_val"},   32'(bus.val),   32'd0);
            chk({tag, "_bad_err"},   32'(bus.err),   32'd1);
            @(negedge clk);
            chk({tag, "_bad_pulse"}, 32'(bus.valid), 32'd0);
        end else begin
            chk({tag, "_busy"}, 32'(bus.rdy), 32'd0);
            lat = 0;
            while (bus.valid !== 1'b1 && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            chk({tag, "_lat"}, 32'(lat),      32'd32);
            chk({tag, "_val"}, 32'(bus.val),  ev);
            chk({tag, "_err"}, 32'(bus.err),  32'd0);
            @(negedge clk);
            chk({tag, "_pulse"},   32'(bus.valid), 32'd0);
            chk({tag, "_rdy_end"}, 32'(bus.rdy),   32'd1);
        end
    endtask

    initial begin
        int pulses;
        int when;
        logic [BIN_W-1:0] seen;
        logic [15:0] b;

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdy",   32'(bus.rdy),   32'd1);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_val",   32'(bus.val),   32'd0);
        chk("rst_err",   32'(bus.err),   32'd0);
        reset = 1'b0;
        @(negedge clk);

        convert(16'h9999, "max");
        convert(16'h0000, "zero");
        convert(16'h1234, "d1234");
        convert(16'h12A4, "bad12A4");
        convert(16'hF000, "badF000");
        convert(16'h0807, "d0807");

        // Start and bcd_in churn during a conversion must be ignored.
        wait_rdy("busy");
        bus.start  = 1'b1;
        bus.bcd_in = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        pulses = 0;
        when   = -1;
        seen   = '0;
        for (int c = 0; c < 60; c++) begin
            if (c == 5) begin
                bus.start  = 1'b1;
                bus.bcd_in = 16'h9999;
            end
            if (c == 8) bus.start = 1'b0;
            if (bus.valid === 1'b1) begin
                pulses++;
                when = c;
                seen = bus.val;
            end
            @(negedge clk);
        end
        chk("busy_pulses", 32'(pulses), 32'd1);
        chk("busy_when",   32'(when),   32'd32);
        chk("busy_val",    32'(seen),   32'd1234);

        // Reset in the middle of a conversion.
        wait_rdy("abort");
        bus.start  = 1'b1;
        bus.bcd_in = 16'h0042;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_rdy",   32'(bus.rdy),   32'd1);
        chk("abort_valid", 32'(bus.valid), 32'd0);
        chk("abort_val",   32'(bus.val),   32'd0);
        chk("abort_err",   32'(bus.err),   32'd0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) pulses++;
        end
        chk("abort_novalid", 32'(pulses), 32'd0);
        convert(16'h0042, "after_abort");

        // Loopback-style sweep: binary count -> BCD -> back.
        for (int n = 0; n < 100; n++) convert(to_bcd(n), "loop_lo");
        for (int n = 4090; n < 4096; n++) convert(to_bcd(n), "loop_hi");
        for (int k = 0; k < 300; k++) convert(to_bcd($urandom_range(0, 4095)), "loop_rnd");

        // Random raw words, including illegal digits.
        for (int k = 0; k < 200; k++) begin
            b = 16'($urandom);
            convert(b, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
